// File: rtl/raise_input_conditioner.sv
// raise_input_conditioner
// Synchronizes and debounces one raw limit-switch line for the lift mechanism,
// producing a clean level for the interrupt-capable PIO plus rise/fall strobes.
// Optional sticky rise flag: define RAISE_COND_EDGE_LATCH_EN to add the
// edge_clear input and edge_flag output.
module raise_input_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter bit INVERT          = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_in,
   output logic level_out,
   output logic rise_pulse,
   output logic fall_pulse,
`ifdef RAISE_COND_EDGE_LATCH_EN
   input  logic edge_clear,
   output logic edge_flag,
`endif
   output logic busy
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      STABLE  = 1'b0,
      QUALIFY = 1'b1
   } state_t;

   state_t                 state;
   logic [CW-1:0]          cnt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;

   // Sample seen by the qualifier, after optional inversion for active-low switches.
   assign s = sync_q[SYNC_STAGES-1] ^ INVERT;

   // Metastability synchronizer chain; bit 0 is the first flop after the pin.
   // NOTE: every flop here is cleared by reset so the chain never holds a stale
   // pre-reset value that would be qualified as a real change.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         // NOTE: non-blocking assignments keep each stage one cycle apart; blocking
         // ones would collapse the chain into a single flop.
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
      end
   end

   // Debounce FSM: qualifies a mismatch for DEBOUNCE_CYCLES samples, then toggles.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= STABLE;
         cnt        <= '0;
         level_out  <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         busy       <= 1'b0;
      end else begin
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         case (state)
            STABLE: begin
               cnt <= '0;
               if (s != level_out) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     level_out  <= s;
                     rise_pulse <= s;
                     fall_pulse <= ~s;
                  end else begin
                     state <= QUALIFY;
                     cnt   <= CW'(1);
                     busy  <= 1'b1;
                  end
               end
            end
            QUALIFY: begin
               if (s == level_out) begin
                  // Bounce shorter than the window: drop the partial count.
                  state <= STABLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state      <= STABLE;
                  cnt        <= '0;
                  busy       <= 1'b0;
                  level_out  <= s;
                  rise_pulse <= s;
                  fall_pulse <= ~s;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= STABLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef RAISE_COND_EDGE_LATCH_EN
   // Sticky rise indicator for software; a new rise beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         edge_flag <= 1'b0;
      end else if (rise_pulse) begin
         edge_flag <= 1'b1;
      end else if (edge_clear) begin
         edge_flag <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_raise_input_conditioner.sv
// Directed bench for raise_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Inputs change on the falling edge; "after edge k" is the k-th falling edge
// following the input change. Edge-latch checks run when RAISE_COND_EDGE_LATCH_EN
// is defined.
module tb_raise_input_conditioner;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic raw_in = 1'b0;
   logic level_out, rise_pulse, fall_pulse, busy;

   logic reset_inv = 1'b1;
   logic raw_inv = 1'b1;
   logic level_inv, rise_inv, fall_inv, busy_inv;

`ifdef RAISE_COND_EDGE_LATCH_EN
   logic edge_clear = 1'b0;
   logic edge_flag;
   logic edge_clear_inv = 1'b0;
   logic edge_flag_inv;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   raise_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .INVERT(1'b0)) dut (
      .clk(clk), .reset(reset), .raw_in(raw_in),
      .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
`ifdef RAISE_COND_EDGE_LATCH_EN
      .edge_clear(edge_clear), .edge_flag(edge_flag),
`endif
      .busy(busy)
   );

   raise_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .INVERT(1'b1)) dut_inv (
      .clk(clk), .reset(reset_inv), .raw_in(raw_inv),
      .level_out(level_inv), .rise_pulse(rise_inv), .fall_pulse(fall_inv),
`ifdef RAISE_COND_EDGE_LATCH_EN
      .edge_clear(edge_clear_inv), .edge_flag(edge_flag_inv),
`endif
      .busy(busy_inv)
   );

   // Observed vector of the main instance: {level, rise, fall, busy}.
   function automatic logic [3:0] obs();
      return {level_out, rise_pulse, fall_pulse, busy};
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      raw_in = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (obs() !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_state: got %b want 0000", obs());
      end
`ifdef RAISE_COND_EDGE_LATCH_EN
      n_cmp++;
      if (edge_flag !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_edge_flag: got %b want 0", edge_flag);
      end
`endif
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (obs() !== 4'b0000) begin
         n_bad++;
         $display("FAIL idle_after_reset: got %b want 0000", obs());
      end
   endtask

   task automatic test_clean_rise();
      logic [3:0] exp;
      raw_in = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         exp = {(k >= 6), (k == 6), 1'b0, (k >= 3 && k <= 5)};
         n_cmp++;
         if (obs() !== exp) begin
            n_bad++;
            $display("FAIL clean_rise edge %0d: got %b want %b", k, obs(), exp);
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_clean_fall();
      logic [3:0] exp;
      raw_in = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         exp = {(k < 6), 1'b0, (k == 6), (k >= 3 && k <= 5)};
         n_cmp++;
         if (obs() !== exp) begin
            n_bad++;
            $display("FAIL clean_fall edge %0d: got %b want %b", k, obs(), exp);
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_bounce();
      logic saw_change = 1'b0;
      logic saw_busy = 1'b0;
      raw_in = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 3) raw_in = 1'b0;
         if (level_out || rise_pulse || fall_pulse) saw_change = 1'b1;
         if (busy) saw_busy = 1'b1;
      end
      n_cmp++;
      if (saw_change !== 1'b0) begin
         n_bad++;
         $display("FAIL bounce_output_change: got %b want 0", saw_change);
      end
      n_cmp++;
      if (saw_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL bounce_busy_seen: got %b want 1", saw_busy);
      end
      n_cmp++;
      if (obs() !== 4'b0000) begin
         n_bad++;
         $display("FAIL bounce_final: got %b want 0000", obs());
      end
   endtask

   task automatic test_reset_mid_qualify();
      logic [3:0] exp;
      raw_in = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (obs() !== 4'b0001) begin
         n_bad++;
         $display("FAIL midq_busy: got %b want 0001", obs());
      end
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (obs() !== 4'b0000) begin
         n_bad++;
         $display("FAIL midq_reset_outputs: got %b want 0000", obs());
      end
      reset = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         exp = {(k >= 6), (k == 6), 1'b0, (k >= 3 && k <= 5)};
         n_cmp++;
         if (obs() !== exp) begin
            n_bad++;
            $display("FAIL midq_recover edge %0d: got %b want %b", k, obs(), exp);
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_invert();
      logic saw_change = 1'b0;
      logic [3:0] exp;
      logic [3:0] got;
      raw_inv = 1'b1;
      reset_inv = 1'b1;
      repeat (2) @(negedge clk);
      reset_inv = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (level_inv || rise_inv || fall_inv) saw_change = 1'b1;
      end
      n_cmp++;
      if (saw_change !== 1'b0) begin
         n_bad++;
         $display("FAIL invert_idle_change: got %b want 0", saw_change);
      end
      raw_inv = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         got = {level_inv, rise_inv, fall_inv, busy_inv};
         exp = {(k >= 6), (k == 6), 1'b0, (k >= 3 && k <= 5)};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL invert_rise edge %0d: got %b want %b", k, got, exp);
         end
      end
   endtask

`ifdef RAISE_COND_EDGE_LATCH_EN
   task automatic test_edge_latch();
      // Return to level 0 first so a fresh rise can be produced.
      raw_in = 1'b0;
      repeat (10) @(negedge clk);
      raw_in = 1'b1;
      repeat (5) @(negedge clk);
      edge_clear = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (rise_pulse !== 1'b1) begin
         n_bad++;
         $display("FAIL latch_rise: got %b want 1", rise_pulse);
      end
      @(negedge clk);
      n_cmp++;
      if (edge_flag !== 1'b1) begin
         n_bad++;
         $display("FAIL latch_set_wins: got %b want 1", edge_flag);
      end
      edge_clear = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (edge_flag !== 1'b1) begin
         n_bad++;
         $display("FAIL latch_hold: got %b want 1", edge_flag);
      end
      edge_clear = 1'b1;
      @(negedge clk);
      edge_clear = 1'b0;
      n_cmp++;
      if (edge_flag !== 1'b0) begin
         n_bad++;
         $display("FAIL latch_clear: got %b want 0", edge_flag);
      end
      edge_clear = 1'b1;
      @(negedge clk);
      edge_clear = 1'b0;
      n_cmp++;
      if (edge_flag !== 1'b0) begin
         n_bad++;
         $display("FAIL latch_clear_idle: got %b want 0", edge_flag);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_clean_rise();
      test_clean_fall();
      test_bounce();
      test_reset_mid_qualify();
      test_invert();
`ifdef RAISE_COND_EDGE_LATCH_EN
      test_edge_latch();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
